serial_add_ctrl: RTL and testbench
==================================

Name: serial_add_ctrl

Overview:
- Sequenced N-bit serial adder with its controller: the FSM, bit counter, operand shift registers and carry flip-flop.
- Accepts parallel operands through a ready/start handshake and adds them LSB-first, one bit per clock, over N clocks.
- Presents a registered parallel sum and carry-out with a one-cycle done pulse.
- Replaces ad-hoc testbench sequencing of the serial adder with a reusable front end.

Parameters:
N, 4, operand/sum width in bits; legal N >= 2; bit counter width = ceil(log2(N+1)).

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous active-low reset
start  input  1  request to begin addition; sampled only when ready=1
abort  input  1  synchronous cancel of an operation in progress
a_in  input  N  operand A, captured on accepted start
b_in  input  N  operand B, captured on accepted start
cin  input  1  carry-in, captured on accepted start
ready  output  1  high in IDLE; start is accepted only then
busy  output  1  high in ADD state
done  output  1  one-cycle pulse: sum/cout updated this cycle
sum  output  N  registered result of last completed addition
cout  output  1  registered carry-out of last completed addition

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, ready=1, busy=0, done=0, sum=0, cout=0. Internal A/B shift registers, carry and counter are cleared.
- States: IDLE, ADD, DONE. All outputs are registered or decoded from state only; no combinational path from inputs to outputs.
- IDLE:
  - On an edge with start=1: load A<=a_in, B<=b_in, carry<=cin, cnt<=0; go to ADD.
  - With start=0: stay in IDLE.
  - abort is ignored in IDLE.
- ADD, each edge:
  - s = A[0]^B[0]^carry.
  - A <= {s, A[N-1:1]}, so sum bits accumulate into A from the MSB side.
  - B <= {1'b0, B[N-1:1]}.
  - carry <= majority(A[0], B[0], carry).
  - cnt <= cnt+1.
  - After the edge where cnt reaches N-1, go to DONE. ADD therefore lasts exactly N clocks.
- Abort: abort=1 sampled in ADD returns to IDLE on that edge. No done pulse; sum/cout keep their previous values. abort takes priority over the final ADD step.
- DONE (one clock):
  - On entry, the edge leaving ADD also writes sum<=A-final and cout<=carry-final; done=1 while in DONE.
  - The next edge returns to IDLE unconditionally. start in DONE is ignored, because ready=0.
- Latency: start sampled at edge k → done high from edge k+N to k+N+1 → ready high again after edge k+N+1. Back-to-back throughput is one result per N+2 clocks.
- start while busy or in DONE has no effect; operand inputs may change freely outside the accepting edge.
- sum/cout never show partial results; they change only on the edge entering DONE.
- Arithmetic: {cout,sum} = a_in + b_in + cin, modulo 2^(N+1); the full carry chain is honoured.
- Reset mid-operation: immediate return to reset values; the in-flight result is discarded.

Test Plan:
1. N=4, a_in=4'b1010, b_in=4'b0011, cin=0, start pulse → done exactly 4 clocks after start edge; sum=4'b1101, cout=0; ready re-asserts the following clock.
2. a_in=4'b1111, b_in=4'b0001, cin=0 → sum=4'b0000, cout=1. Then a_in=4'b0111, b_in=4'b1000, cin=1 → sum=4'b0000, cout=1.
3. Accepted start with 0101+0001. Hold start=1 and change a_in/b_in during ADD and DONE → sum=4'b0110, cout=0. A second operation begins only on the first IDLE edge after DONE.
4. Start 1010+0011; previous sum=4'b0110. Pulse abort on the 3rd ADD clock → no done pulse, sum stays 4'b0110, ready=1 next cycle. A new start 0001+0001 → sum=4'b0010.
5. Drive rst low asynchronously mid-ADD, between clock edges → ready=1, busy=0, done=0, sum=0, cout=0 immediately. After release, a fresh 0011+0011 → sum=4'b0110.
6. Exhaustive sweep of all a_in, b_in, cin for N=4 with start issued on every ready cycle → every {cout,sum} matches a_in+b_in+cin; done count equals start count.

Source files
------------

// File: rtl/serial_add_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | serial_add_ctrl: LSB-first N-bit serial adder with start/ready front end. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module serial_add_ctrl #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         abort,
  input  logic [N-1:0] a_in,
  input  logic [N-1:0] b_in,
  input  logic         cin,
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] sum,
  output logic         cout
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] C_LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   a_q, a_d;
  logic [N-1:0]   b_q, b_d;
  logic           carry_q, carry_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   sum_q, sum_d;
  logic           cout_q, cout_d;
  logic           bit_s;
  logic           bit_c;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    bit_s   = a_q[0] ^ b_q[0] ^ carry_q;
    bit_c   = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a_in;
          b_d     = b_in;
          carry_d = cin;
          cnt_d   = '0;
          state_d = S_ADD;
        end
      end
      S_ADD: begin
        // abort wins over the final step so a late cancel never publishes
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          a_d     = {bit_s, a_q[N-1:1]};
          b_d     = {1'b0, b_q[N-1:1]};
          carry_d = bit_c;
          cnt_d   = cnt_q + CW'(1);
          if (cnt_q == C_LAST) begin
            sum_d   = {bit_s, a_q[N-1:1]};
            cout_d  = bit_c;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign ready = (state_q == S_IDLE);
  assign busy  = (state_q == S_ADD);
  assign done  = (state_q == S_DONE);
  assign sum   = sum_q;
  assign cout  = cout_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
`default_nettype none
// Self-checking bench for serial_add_ctrl: directed scenarios, exhaustive
// sweep and randomized operations against an arithmetic reference model.
module tb_serial_add_ctrl;

  localparam int N = 4;
  localparam int TMO = 50;

  logic         clk;
  logic         rst;
  logic         start;
  logic         abort;
  logic [N-1:0] a_in;
  logic [N-1:0] b_in;
  logic         cin;
  logic         ready;
  logic         busy;
  logic         done;
  logic [N-1:0] sum;
  logic         cout;

  int n_checks;
  int n_fail;
  int n_starts;
  int n_dones;

  serial_add_ctrl #(.N(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .abort (abort),
    .a_in  (a_in),
    .b_in  (b_in),
    .cin   (cin),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present operands with start for exactly one edge; caller is in IDLE.
  task automatic start_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic c);
    a_in  = a;
    b_in  = b;
    cin   = c;
    start = 1'b1;
    step();
    start = 1'b0;
    n_starts++;
  endtask

  // Count edges until done is seen, bounded; optionally scramble operand inputs.
  task automatic wait_done(input bit scramble, output int n);
    n = 0;
    while (!done && n < TMO) begin
      if (scramble) begin
        a_in = N'($urandom);
        b_in = N'($urandom);
        cin  = 1'($urandom);
      end
      step();
      n++;
    end
    if (done) n_dones++;
  endtask

  function automatic logic [N:0] model_add(input logic [N-1:0] a, input logic [N-1:0] b, input logic c);
    return ({1'b0, a} + {1'b0, b} + {{N{1'b0}}, c});
  endfunction

  task automatic test_reset();
    n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    n_checks++; if (sum !== '0) begin n_fail++; $display("FAIL reset_sum: got %b expected 0", sum); end
    n_checks++; if (cout !== 1'b0) begin n_fail++; $display("FAIL reset_cout: got %b expected 0", cout); end
  endtask

  task automatic test_basic();
    int n;
    start_op(4'b1010, 4'b0011, 1'b0);
    n_checks++; if (busy !== 1'b1 || ready !== 1'b0) begin n_fail++; $display("FAIL basic_busy: got busy=%b ready=%b expected busy=1 ready=0", busy, ready); end
    wait_done(1'b1, n);
    n_checks++; if (n !== N) begin n_fail++; $display("FAIL basic_latency: got %0d expected %0d", n, N); end
    n_checks++; if (sum !== 4'b1101 || cout !== 1'b0) begin n_fail++; $display("FAIL basic_sum: got %b/%b expected 0/1101", cout, sum); end
    n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL basic_ready_in_done: got %b expected 0", ready); end
    step();
    n_checks++; if (ready !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL basic_ready_after: got ready=%b done=%b expected 1/0", ready, done); end

    start_op(4'b1111, 4'b0001, 1'b0);
    wait_done(1'b0, n);
    n_checks++; if ({cout, sum} !== 5'b10000) begin n_fail++; $display("FAIL carry_full: got %b expected 10000", {cout, sum}); end
    step();
    start_op(4'b0111, 4'b1000, 1'b1);
    wait_done(1'b0, n);
    n_checks++; if ({cout, sum} !== 5'b10000) begin n_fail++; $display("FAIL carry_cin: got %b expected 10000", {cout, sum}); end
    step();
  endtask

  task automatic test_hold_start();
    int n;
    a_in  = 4'b0101;
    b_in  = 4'b0001;
    cin   = 1'b0;
    start = 1'b1;
    step();
    n_starts++;
    wait_done(1'b1, n);
    n_checks++; if (n !== N) begin n_fail++; $display("FAIL hold_latency: got %0d expected %0d", n, N); end
    n_checks++; if ({cout, sum} !== 5'b00110) begin n_fail++; $display("FAIL hold_sum: got %b expected 00110", {cout, sum}); end
    // start still high through DONE; next edge must land in IDLE, not ADD
    step();
    n_checks++; if (ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL hold_no_start_in_done: got ready=%b busy=%b expected 1/0", ready, busy); end
    a_in = 4'b0010;
    b_in = 4'b0011;
    cin  = 1'b0;
    step();
    n_starts++;
    start = 1'b0;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL hold_second_accept: got busy=%b expected 1", busy); end
    wait_done(1'b1, n);
    n_checks++; if ({cout, sum} !== 5'b00101) begin n_fail++; $display("FAIL hold_second_sum: got %b expected 00101", {cout, sum}); end
    step();
  endtask

  task automatic test_abort();
    int n;
    start_op(4'b0101, 4'b0001, 1'b0);
    wait_done(1'b0, n);
    step();
    start_op(4'b1010, 4'b0011, 1'b0);
    step();
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    n_checks++; if (ready !== 1'b1 || done !== 1'b0 || sum !== 4'b0110) begin n_fail++; $display("FAIL abort_mid: got ready=%b done=%b sum=%b expected 1/0/0110", ready, done, sum); end
    n = 0;
    repeat (N + 2) begin step(); if (done) n++; end
    n_checks++; if (n !== 0) begin n_fail++; $display("FAIL abort_no_done: got %0d done pulses expected 0", n); end
    // abort on the final ADD edge must still cancel
    start_op(4'b1111, 4'b1111, 1'b1);
    repeat (N - 1) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    n_checks++; if (ready !== 1'b1 || done !== 1'b0 || {cout, sum} !== 5'b00110) begin n_fail++; $display("FAIL abort_last: got ready=%b done=%b res=%b expected 1/0/00110", ready, done, {cout, sum}); end
    start_op(4'b0001, 4'b0001, 1'b0);
    wait_done(1'b0, n);
    n_checks++; if ({cout, sum} !== 5'b00010) begin n_fail++; $display("FAIL abort_recover: got %b expected 00010", {cout, sum}); end
    step();
  endtask

  task automatic test_async_reset();
    int n;
    start_op(4'b0111, 4'b0110, 1'b1);
    step();
    #2;
    rst = 1'b0;
    #1;
    n_checks++; if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || sum !== '0 || cout !== 1'b0) begin
      n_fail++; $display("FAIL async_reset: got r=%b b=%b d=%b s=%b c=%b expected 1/0/0/0000/0", ready, busy, done, sum, cout);
    end
    #2;
    rst = 1'b1;
    step();
    start_op(4'b0011, 4'b0011, 1'b0);
    wait_done(1'b0, n);
    n_checks++; if ({cout, sum} !== 5'b00110) begin n_fail++; $display("FAIL async_recover: got %b expected 00110", {cout, sum}); end
    step();
  endtask

  task automatic test_sweep();
    int n;
    int bad;
    int s0;
    int d0;
    logic [N:0] exp;
    bad = 0;
    s0 = n_starts;
    d0 = n_dones;
    for (int a = 0; a < (1 << N); a++) begin
      for (int b = 0; b < (1 << N); b++) begin
        for (int c = 0; c < 2; c++) begin
          exp = model_add(N'(a), N'(b), 1'(c));
          start_op(N'(a), N'(b), 1'(c));
          wait_done(1'b1, n);
          n_checks++;
          if (n !== N || {cout, sum} !== exp) begin
            n_fail++;
            if (bad < 8) $display("FAIL sweep %0d+%0d+%0d: got %b after %0d clks expected %b after %0d", a, b, c, {cout, sum}, n, exp, N);
            bad++;
          end
          step();
        end
      end
    end
    n_checks++; if ((n_dones - d0) !== (n_starts - s0)) begin n_fail++; $display("FAIL sweep_done_count: got %0d expected %0d", n_dones - d0, n_starts - s0); end
  endtask

  task automatic test_random();
    int n;
    int k;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic c;
    logic [N:0] last;
    logic [N:0] exp;
    last = {cout, sum};
    for (int i = 0; i < 300; i++) begin
      a = N'($urandom);
      b = N'($urandom);
      c = 1'($urandom);
      exp = model_add(a, b, c);
      start_op(a, b, c);
      if ($urandom_range(0, 3) == 0) begin
        k = $urandom_range(0, N - 1);
        repeat (k) begin
          start = 1'($urandom);
          step();
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        start = 1'b0;
        n_checks++;
        if (ready !== 1'b1 || done !== 1'b0 || {cout, sum} !== last) begin
          n_fail++; $display("FAIL rand_abort %0d: got ready=%b done=%b res=%b expected 1/0/%b", i, ready, done, {cout, sum}, last);
        end
      end else begin
        wait_done(1'b1, n);
        n_checks++;
        if (n !== N || {cout, sum} !== exp) begin
          n_fail++; $display("FAIL rand_add %0d: got %b after %0d clks expected %b after %0d", i, {cout, sum}, n, exp, N);
        end
        last = exp;
        step();
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    n_starts = 0;
    n_dones  = 0;
    rst   = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    a_in  = '0;
    b_in  = '0;
    cin   = 1'b0;
    #12;
    test_reset();
    rst = 1'b1;
    step();
    test_reset();
    test_basic();
    test_hold_start();
    test_abort();
    test_async_reset();
    test_sweep();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
